// File: rtl/data_mem_dump_reader_pkg.sv
// Shared constants for the data memory readback unit: widths common to the
// data memory and processor top, plus the dump FSM state encoding.
package data_mem_dump_reader_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 10;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_SEND    = 3'd3,
        ST_FINISH  = 3'd4
    } state_t;

endpackage

// File: rtl/data_mem_dump_reader.sv
// Data memory dump reader: on an accepted start it freezes the processor,
// walks the latched inclusive address range one word at a time and emits
// each word on a valid/ready stream tagged with its address and a last flag.
module data_mem_dump_reader
    import data_mem_dump_reader_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] first_addr,
    input  logic [ADDR_W-1:0] last_addr,
    output logic              busy,
    output logic              halt,
    output logic              err,
    output logic              done,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_last
);

    state_t            r_state;
    state_t            w_next_state;
    logic              w_accept;
    logic              w_reject;
    logic              w_handshake;
    logic [ADDR_W-1:0] r_cur;
    logic [ADDR_W-1:0] r_last_addr;
    logic [ADDR_W-1:0] r_out_addr;
    logic [DATA_W-1:0] r_out_data;
    logic              r_out_last;
    logic              r_err;

    // State register; reset aborts any dump in progress without done/err.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clock) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next_state;
    end

    // Next-state decode and state-derived outputs.
    // NOTE: every signal gets a default before the case so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_reject     = 1'b0;
        w_handshake  = 1'b0;
        busy         = (r_state != ST_IDLE);
        halt         = (r_state != ST_IDLE);
        mem_rd_en    = 1'b0;
        out_valid    = 1'b0;
        done         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    if (first_addr <= last_addr) begin
                        w_accept     = 1'b1;
                        w_next_state = ST_ISSUE;
                    end else begin
                        w_reject     = 1'b1;
                    end
                end
            end
            ST_ISSUE: begin
                mem_rd_en    = 1'b1;
                w_next_state = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                w_next_state = ST_SEND;
            end
            ST_SEND: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_handshake  = 1'b1;
                    w_next_state = r_out_last ? ST_FINISH : ST_ISSUE;
                end
            end
            ST_FINISH: begin
                done         = 1'b1;
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Address counter, latched bound, captured output word and err pulse.
    // The last-word compare is taken before any increment, and the counter
    // only advances on non-final handshakes, so it never wraps past the top.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_cur       <= '0;
            r_last_addr <= '0;
            r_out_data  <= '0;
            r_out_addr  <= '0;
            r_out_last  <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_err <= w_reject;
            if (w_accept) begin
                r_cur       <= first_addr;
                r_last_addr <= last_addr;
            end
            if (r_state == ST_CAPTURE) begin
                r_out_data <= mem_rd_data;
                r_out_addr <= r_cur;
                r_out_last <= (r_cur == r_last_addr);
            end
            if (w_handshake && !r_out_last) begin
                r_cur <= r_cur + ADDR_W'(1);
            end
        end
    end

    assign mem_addr = r_cur;
    assign out_data = r_out_data;
    assign out_addr = r_out_addr;
    assign out_last = r_out_last;
    assign err      = r_err;

endmodule

// File: tb/tb_data_mem_dump_reader.sv
// Self-checking bench for data_mem_dump_reader: a one-cycle-latency data
// memory model, a scoreboard of expected beats filled from the memory array
// when each dump is requested, and a monitor that pops it on every handshake.
module tb_data_mem_dump_reader;

    localparam int DW = 16;
    localparam int AW = 10;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] first_addr = '0;
    logic [AW-1:0] last_addr = '0;
    logic          busy, halt, err, done, mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rd_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic [AW-1:0] out_addr;
    logic          out_last;

    always #5 clock = ~clock;

    data_mem_dump_reader #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clock(clock), .reset(reset), .start(start),
        .first_addr(first_addr), .last_addr(last_addr),
        .busy(busy), .halt(halt), .err(err), .done(done),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_addr(out_addr), .out_last(out_last)
    );

    // Data memory: read data valid one cycle after the strobe.
    logic [DW-1:0] mem [1<<AW];
    always @(posedge clock) if (mem_rd_en) mem_rd_data <= mem[mem_addr];

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    beat_t sb[$];
    int    n_cmp = 0;
    int    n_fail = 0;
    int    stall_cycles = 0;
    bit    rnd_ready = 1'b0;
    int    dump_first = 0;
    int    dump_last = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Sink: optional forced stall counted in valid cycles, else ready or random.
    always begin
        @(posedge clock);
        #1;
        if (stall_cycles > 0) begin
            out_ready = 1'b0;
            if (out_valid) stall_cycles--;
        end else begin
            out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: beat compare, hold stability while stalled, read range, done timing.
    bit    exp_done = 1'b0;
    bit    stall_prev = 1'b0;
    beat_t held;
    always @(negedge clock) begin
        beat_t e;
        if (reset) begin
            stall_prev = 1'b0;
            exp_done   = 1'b0;
        end else begin
            check("halt_tracks_busy", 32'(halt), 32'(busy));
            if (exp_done || done) check("done_after_last", 32'(done), 32'(exp_done));
            exp_done = 1'b0;
            if (mem_rd_en)
                check("rd_in_range", 32'(int'(mem_addr) >= dump_first && int'(mem_addr) <= dump_last), 32'd1);
            if (out_valid) begin
                if (stall_prev) begin
                    check("hold_addr", 32'(out_addr), 32'(held.addr));
                    check("hold_data", 32'(out_data), 32'(held.data));
                    check("hold_last", 32'(out_last), 32'(held.last));
                end
                if (out_ready) begin
                    if (sb.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL unexpected_beat: got addr 0x%0h, expected none", out_addr);
                    end else begin
                        e = sb.pop_front();
                        check("beat_addr", 32'(out_addr), 32'(e.addr));
                        check("beat_data", 32'(out_data), 32'(e.data));
                        check("beat_last", 32'(out_last), 32'(e.last));
                        if (e.last) exp_done = 1'b1;
                    end
                    stall_prev = 1'b0;
                end else begin
                    stall_prev = 1'b1;
                    held.addr  = out_addr;
                    held.data  = out_data;
                    held.last  = out_last;
                end
            end else begin
                stall_prev = 1'b0;
            end
        end
    end

    task automatic pulse_start(input logic [AW-1:0] f, input logic [AW-1:0] l);
        @(posedge clock);
        #1;
        first_addr = f;
        last_addr  = l;
        start      = 1'b1;
        @(posedge clock);
        #1;
        start      = 1'b0;
        first_addr = AW'($urandom);
        last_addr  = AW'($urandom);
    endtask

    task automatic expect_range(input logic [AW-1:0] f, input logic [AW-1:0] l);
        dump_first = int'(f);
        dump_last  = int'(l);
        for (int a = int'(f); a <= int'(l); a++)
            sb.push_back('{addr: AW'(a), data: mem[a], last: (a == int'(l))});
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_halt"}, 32'(halt), 0);
        check({tag, "_err"}, 32'(err), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_rd_en"}, 32'(mem_rd_en), 0);
        check({tag, "_mem_addr"}, 32'(mem_addr), 0);
        check({tag, "_valid"}, 32'(out_valid), 0);
        check({tag, "_data"}, 32'(out_data), 0);
        check({tag, "_addr"}, 32'(out_addr), 0);
        check({tag, "_last"}, 32'(out_last), 0);
    endtask

    task automatic run_dump(input logic [AW-1:0] f, input logic [AW-1:0] l,
                            input int stall, input bit rnd, input bit poke);
        int lat;
        int guard;
        expect_range(f, l);
        stall_cycles = stall;
        rnd_ready    = rnd;
        pulse_start(f, l);
        lat = 0;
        while (1) begin
            @(negedge clock);
            lat++;
            if (lat == 1) begin
                check("busy_rise", 32'(busy), 1);
                check("halt_rise", 32'(halt), 1);
            end
            if (out_valid || lat >= 20) break;
        end
        check("first_valid_latency", 32'(lat), 3);
        if (poke) begin
            @(posedge clock);
            #1;
            start      = 1'b1;
            first_addr = AW'(3);
            last_addr  = AW'(1000);
            @(posedge clock);
            #1;
            start      = 1'b0;
        end
        guard = 0;
        do begin
            @(negedge clock);
            guard++;
        end while (!done && guard < 400);
        check("done_seen", 32'(done), 1);
        check("busy_in_finish", 32'(busy), 1);
        check("halt_in_finish", 32'(halt), 1);
        check("beats_left", 32'(sb.size()), 0);
        @(negedge clock);
        check("busy_drop", 32'(busy), 0);
        check("halt_drop", 32'(halt), 0);
        check("done_one_cycle", 32'(done), 0);
        stall_cycles = 0;
        rnd_ready    = 1'b0;
    endtask

    initial begin
        int guard;
        logic [AW-1:0] f, l;
        int len;

        for (int i = 0; i < (1 << AW); i++) mem[i] = DW'($urandom);
        mem[0] = 16'h0005;
        mem[1] = 16'h00A3;
        mem[2] = 16'hFFFF;
        mem[7] = 16'h1234;

        repeat (2) @(posedge clock);
        @(negedge clock);
        check_all_zero("reset");
        @(posedge clock);
        #1;
        reset = 1'b0;

        // Basic three-word dump, then the same with a 5-cycle stall on beat 0.
        run_dump(AW'(0), AW'(2), 0, 1'b0, 1'b0);
        run_dump(AW'(0), AW'(2), 5, 1'b0, 1'b0);
        // Single-word range.
        run_dump(AW'(7), AW'(7), 0, 1'b0, 1'b0);

        // Reversed range is rejected with a one-cycle err.
        pulse_start(AW'(5), AW'(3));
        @(negedge clock);
        check("err_pulse", 32'(err), 1);
        check("err_busy", 32'(busy), 0);
        check("err_halt", 32'(halt), 0);
        check("err_valid", 32'(out_valid), 0);
        @(negedge clock);
        check("err_one_cycle", 32'(err), 0);
        check("err_still_idle", 32'(busy), 0);

        // Top of the address space: must stop at 1023 without wrapping.
        mem[0] = 16'hDEAD;
        run_dump(AW'(1022), AW'(1023), 0, 1'b0, 1'b0);

        // Start re-pulsed mid-dump with different bounds is ignored.
        mem[0] = 16'h0005;
        run_dump(AW'(0), AW'(2), 0, 1'b0, 1'b1);

        // Reset while stalled in SEND aborts with no done.
        expect_range(AW'(0), AW'(2));
        stall_cycles = 1000;
        pulse_start(AW'(0), AW'(2));
        guard = 0;
        do begin
            @(negedge clock);
            guard++;
        end while (!out_valid && guard < 20);
        check("reset_test_in_send", 32'(out_valid), 1);
        @(posedge clock);
        #1;
        reset = 1'b1;
        sb.delete();
        @(posedge clock);
        @(negedge clock);
        check_all_zero("mid_reset");
        @(posedge clock);
        #1;
        reset        = 1'b0;
        stall_cycles = 0;
        @(negedge clock);
        check("no_done_after_abort", 32'(done), 0);
        run_dump(AW'(0), AW'(0), 0, 1'b0, 1'b0);

        // Randomized ranges and contents with a random sink.
        for (int k = 0; k < 8; k++) begin
            len = $urandom_range(1, 8);
            f   = AW'($urandom_range(0, (1 << AW) - 1));
            l   = (int'(f) + len - 1 > (1 << AW) - 1) ? AW'((1 << AW) - 1) : AW'(int'(f) + len - 1);
            for (int a = int'(f); a <= int'(l); a++) mem[a] = DW'($urandom);
            run_dump(f, l, 0, 1'b1, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
